// File: rtl/mips_instr_encoder.sv
// Packs symbolic MIPS instruction requests into 32-bit machine words and streams them
// out through a small show-ahead FIFO, tagging each word with its sequential word address.
module mips_instr_encoder #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [3:0]                      in_op,
    input  logic [4:0]                      in_rs,
    input  logic [4:0]                      in_rt,
    input  logic [4:0]                      in_rd,
    input  logic [15:0]                     in_imm,
    input  logic [25:0]                     in_target,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [31:0]                     out_instr,
    output logic [ADDR_W-1:0]               out_addr,
    output logic                            err_illegal,
    output logic [$clog2(FIFO_DEPTH):0]     fill_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [31:0]       mem_instr [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_addr  [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] addr_cnt;
    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              accept;
    logic              push;
    logic              pop;

    // Opcode/funct map must stay bit-identical to the decoder's.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (in_op)
            4'd0:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
            4'd1:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
            4'd2:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
            4'd3:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
            4'd4:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
            4'd5:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b011100};
            4'd6:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
            4'd7:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
            4'd8:    enc_word = {6'b001000, in_rs, in_rt, in_imm};
            4'd9:    enc_word = {6'b000100, in_rs, in_rt, in_imm};
            4'd10:   enc_word = {6'b000010, in_target};
            4'd11:   enc_word = '0;
            default: enc_legal = 1'b0;
        endcase
    end

    assign in_ready  = (count < DEPTH_C);
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && enc_legal;
    assign pop       = out_valid && out_ready;

    assign out_instr  = out_valid ? mem_instr[rd_ptr] : '0;
    assign out_addr   = out_valid ? mem_addr[rd_ptr] : '0;
    assign fill_count = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= enc_word;
            mem_addr[wr_ptr]  <= addr_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            addr_cnt    <= '0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= accept && !enc_legal;
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                addr_cnt <= addr_cnt + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench: queue-based reference model of the encoder FIFO, checked every cycle,
// plus directed scenarios pinned to hand-computed words and addresses.
module tb_mips_instr_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  in_op = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;

    logic        in_ready, out_valid, err_illegal;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic [2:0]  fill_count;

    logic        in_ready2, out_valid2, err_illegal2;
    logic [31:0] out_instr2;
    logic [1:0]  out_addr2;
    logic [2:0]  fill_count2;

    mips_instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .err_illegal(err_illegal), .fill_count(fill_count));

    mips_instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2), .out_addr(out_addr2),
        .err_illegal(err_illegal2), .fill_count(fill_count2));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  a8;
        logic [1:0]  a2;
    } ent_t;

    ent_t mq[$];
    ent_t log_q[$];
    logic [7:0] ma8;
    logic [1:0] ma2;
    logic       m_err;
    logic       m_acc;
    int         msz;
    int         err_seen;
    int         n_pass = 0;
    int         n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        logic [5:0] code;
        code = 6'h00;
        if (op <= 4'd5) begin
            case (op)
                4'd0: code = 6'h20;
                4'd1: code = 6'h22;
                4'd2: code = 6'h24;
                4'd3: code = 6'h25;
                4'd4: code = 6'h2A;
                default: code = 6'h1C;
            endcase
            return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(code);
        end else if (op <= 4'd9) begin
            case (op)
                4'd6: code = 6'h23;
                4'd7: code = 6'h2B;
                4'd8: code = 6'h08;
                default: code = 6'h04;
            endcase
            return (32'(code) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
        end else if (op == 4'd10) begin
            return (32'd2 << 26) | 32'(tgt);
        end
        return 32'h0;
    endfunction

    // Reference model: updated on each rising edge from the inputs held stable across it.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            ma8 = '0;
            ma2 = '0;
            m_err = 1'b0;
            m_acc = 1'b0;
        end else begin
            msz = mq.size();
            m_acc = in_valid && (msz < 4);
            m_err = m_acc && (in_op >= 4'd12);
            if (msz > 0 && out_ready) void'(mq.pop_front());
            if (m_acc && in_op < 4'd12) begin
                mq.push_back('{enc(in_op, in_rs, in_rt, in_rd, in_imm, in_target), ma8, ma2});
                ma8 = ma8 + 8'd1;
                ma2 = ma2 + 2'd1;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 4));
        chk("fill_count", 32'(fill_count), 32'(mq.size()));
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("err_illegal", 32'(err_illegal), 32'(m_err));
        chk("out_instr", out_instr, (mq.size() > 0) ? mq[0].instr : 32'h0);
        chk("out_addr", 32'(out_addr), (mq.size() > 0) ? 32'(mq[0].a8) : 32'h0);
        chk("out_addr_w2", 32'(out_addr2), (mq.size() > 0) ? 32'(mq[0].a2) : 32'h0);
        chk("out_instr_w2", out_instr2, (mq.size() > 0) ? mq[0].instr : 32'h0);
        if (!rst && out_valid && out_ready) log_q.push_back('{out_instr, out_addr, out_addr2});
        if (!rst && err_illegal) err_seen++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        log_q.delete();
        err_seen = 0;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        bit ok;
        ok = 1'b0;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            idle(1);
            if (m_acc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic chk_log(input int i, input logic [31:0] instr, input logic [7:0] a8);
        if (log_q.size() <= i) begin
            chk("log_missing", 32'(log_q.size()), 32'(i + 1));
        end else begin
            chk("log_instr", log_q[i].instr, instr);
            chk("log_addr", 32'(log_q[i].a8), 32'(a8));
        end
    endtask

    initial begin
        err_seen = 0;
        idle(2);
        rst = 1'b0;

        chk("pin_add", enc(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0), 32'h00221820);
        chk("pin_lw", enc(4'd6, 5'd0, 5'd8, 5'd0, 16'h0004, 26'h0), 32'h8C080004);
        chk("pin_j", enc(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010), 32'h08000010);

        // single ADD
        out_ready = 1'b1;
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        idle(3);
        chk_log(0, 32'h00221820, 8'd0);
        chk("add_drained", 32'(fill_count), 32'd0);

        // mixed formats
        do_reset();
        send(4'd6, 5'd0, 5'd8, 5'd0, 16'h0004, 26'h0);
        send(4'd9, 5'd8, 5'd9, 5'd0, 16'hFFFF, 26'h0);
        send(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010);
        send(4'd5, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
        idle(3);
        chk_log(0, 32'h8C080004, 8'd0);
        chk_log(1, 32'h1109FFFF, 8'd1);
        chk_log(2, 32'h08000010, 8'd2);
        chk_log(3, 32'h0085301C, 8'd3);

        // fill to full, then drain
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'd1, 5'(i), 5'd2, 5'd3, 16'h0, 26'h0);
        idle(1);
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(fill_count), 32'd4);
        in_op = 4'd8; in_rs = 5'd7; in_rt = 5'd7; in_imm = 16'h0042; in_valid = 1'b1;
        idle(2);
        chk("full_hold", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        send(4'd8, 5'd7, 5'd7, 5'd0, 16'h0042, 26'h0);
        idle(6);
        for (int i = 0; i < 4; i++) chk_log(i, enc(4'd1, 5'(i), 5'd2, 5'd3, 16'h0, 26'h0), 8'(i));
        chk_log(4, 32'h20E70042, 8'd4);

        // illegal op between two ADDIs
        do_reset();
        send(4'd8, 5'd1, 5'd2, 5'd0, 16'h0010, 26'h0);
        send(4'd13, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        send(4'd8, 5'd3, 5'd4, 5'd0, 16'h0020, 26'h0);
        idle(3);
        chk("err_pulses", 32'(err_seen), 32'd1);
        chk("illegal_queued", 32'(log_q.size()), 32'd2);
        chk_log(0, 32'h20220010, 8'd0);
        chk_log(1, 32'h20640020, 8'd1);

        // NOPs, 2-bit address wrap on the narrow instance
        do_reset();
        for (int i = 0; i < 5; i++) send(4'd11, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        idle(3);
        for (int i = 0; i < 5; i++) begin
            chk_log(i, 32'h0, 8'(i));
            if (log_q.size() > i) chk("nop_addr_w2", 32'(log_q[i].a2), (i == 4) ? 32'd0 : 32'(i));
        end

        // reset with words buffered
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(4'd2, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
        chk("pre_rst_count", 32'(fill_count), 32'd3);
        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(fill_count), 32'd0);
        out_ready = 1'b1;
        send(4'd3, 5'd9, 5'd10, 5'd11, 16'h0, 26'h0);
        idle(3);
        chk_log(0, 32'h012A5825, 8'd0);

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            in_op     = 4'($urandom_range(0, 15));
            in_rs     = 5'($urandom);
            in_rt     = 5'($urandom);
            in_rd     = 5'($urandom);
            in_imm    = 16'($urandom);
            in_target = 26'($urandom);
            idle(1);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(10);
        chk("final_empty", 32'(fill_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
